// File: rtl/ram_arbiter_if.sv
// Shared RAM port types and the ram_if bundle between the arbiter (ramctrl) and the RAM.
// The ramctrl side drives the request fields, and the RAM side drives load and state.
package ram_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {
      RAM_FREE  = 2'd0,
      RAM_BUSY  = 2'd1,
      RAM_DONE  = 2'd2,
      RAM_ERROR = 2'd3
   } ram_state_t;
endpackage

interface ram_if;
   import ram_pkg::*;
   word_t      addr;
   logic [3:0] wen;
   logic       ren;
   word_t      store;
   word_t      load;
   ram_state_t state;

   modport ramctrl (output addr, wen, ren, store, input load, state);
   modport ram     (input addr, wen, ren, store, output load, state);
endinterface

// File: rtl/ram_arbiter.sv
// Merges instruction fetch and data access onto one RAM port with one access in flight.
// Hit arrives one cycle after the RAM reports DONE or ERROR, or after TIMEOUT cycles; requesters hold until hit.
module ram_arbiter
   import ram_pkg::*;
#(
   parameter int TIMEOUT = 256
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       iren,
   input  word_t      iaddr,
   output word_t      iload,
   output logic       ihit,
   output logic       ierr,
   input  logic       dren,
   input  logic [3:0] dwen,
   input  word_t      daddr,
   input  word_t      dstore,
   output word_t      dload,
   output logic       dhit,
   output logic       derr,
   ram_if.ramctrl     ramif
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state;
   logic          grant_d;
   logic          last_d;
   logic [CW-1:0] cnt;

   logic d_pend;
   logic i_pend;
   logic pick_d;
   logic acc_ok;
   logic acc_end;

   assign d_pend  = dren | (dwen != 4'd0);
   assign i_pend  = iren;
   // Under contention, take the port that did not win the previous grant.
   assign pick_d  = d_pend & (~i_pend | ~last_d);
   assign acc_ok  = (ramif.state == RAM_DONE);
   assign acc_end = acc_ok | (ramif.state == RAM_ERROR) | (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         grant_d     <= 1'b0;
         last_d      <= 1'b0;
         cnt         <= '0;
         ramif.addr  <= '0;
         ramif.wen   <= 4'd0;
         ramif.ren   <= 1'b0;
         ramif.store <= '0;
         iload       <= '0;
         dload       <= '0;
         ihit        <= 1'b0;
         dhit        <= 1'b0;
         ierr        <= 1'b0;
         derr        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (d_pend | i_pend) begin
                  grant_d <= pick_d;
                  last_d  <= pick_d;
                  cnt     <= '0;
                  state   <= ACCESS;
                  if (pick_d) begin
                     // A nonzero byte enable makes this a write even if dren is also set.
                     ramif.addr  <= daddr;
                     ramif.store <= dstore;
                     ramif.wen   <= dwen;
                     ramif.ren   <= (dwen == 4'd0);
                  end else begin
                     ramif.addr  <= iaddr;
                     ramif.store <= '0;
                     ramif.wen   <= 4'd0;
                     ramif.ren   <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               cnt <= cnt + 1'b1;
               if (acc_end) begin
                  state       <= RESP;
                  ramif.addr  <= '0;
                  ramif.wen   <= 4'd0;
                  ramif.ren   <= 1'b0;
                  ramif.store <= '0;
                  if (grant_d) begin
                     dload <= acc_ok ? ramif.load : '0;
                     dhit  <= 1'b1;
                     derr  <= ~acc_ok;
                  end else begin
                     iload <= acc_ok ? ramif.load : '0;
                     ihit  <= 1'b1;
                     ierr  <= ~acc_ok;
                  end
               end
            end
            RESP: begin
               // Spending this cycle here keeps a request still held during the hit from re-issuing.
               ihit  <= 1'b0;
               dhit  <= 1'b0;
               ierr  <= 1'b0;
               derr  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM with configurable latency/outcome, scoreboard of expected hits.
module tb_ram_arbiter;
   import ram_pkg::*;

   localparam int TO = 4;

   logic        clk;
   logic        nrst;
   logic        iren;
   word_t       iaddr;
   word_t       iload;
   logic        ihit;
   logic        ierr;
   logic        dren;
   logic [3:0]  dwen;
   word_t       daddr;
   word_t       dstore;
   word_t       dload;
   logic        dhit;
   logic        derr;

   ram_if rif ();

   ram_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .nrst(nrst),
      .iren(iren), .iaddr(iaddr), .iload(iload), .ihit(ihit), .ierr(ierr),
      .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dhit(dhit), .derr(derr),
      .ramif(rif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: BUSY for ram_busy cycles, then DONE/ERROR (mode 0/1), or BUSY forever (mode 2).
   int    ram_busy;
   int    ram_mode;
   word_t ram_data;
   logic  use_addr_data;
   int    acc_cyc;
   logic  ram_act;

   assign ram_act = rif.ren | (rif.wen != 4'd0);

   always @(posedge clk or negedge nrst) begin
      if (!nrst) acc_cyc <= 0;
      else       acc_cyc <= ram_act ? acc_cyc + 1 : 0;
   end

   always_comb begin
      rif.state = RAM_FREE;
      if (ram_act) begin
         if (acc_cyc < ram_busy || ram_mode == 2) rif.state = RAM_BUSY;
         else if (ram_mode == 1)                  rif.state = RAM_ERROR;
         else                                     rif.state = RAM_DONE;
      end
      rif.load = use_addr_data ? (rif.addr ^ 32'h5A5A_0000) : ram_data;
   end

   typedef struct {
      logic  port_d;
      logic  err;
      word_t load;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp;
   int   n_fail;

   function automatic logic [34:0] obs(input logic port_d);
      return port_d ? {dhit, ihit, derr, dload} : {ihit, dhit, ierr, iload};
   endfunction

   function automatic exp_t mk(input logic port_d, input logic err, input word_t load);
      exp_t e;
      e.port_d = port_d;
      e.err    = err;
      e.load   = load;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hit(input int max, output bit got, output int cyc);
      got = 1'b0;
      cyc = 0;
      for (int c = 1; c <= max; c++) begin
         tick();
         if (ihit || dhit) begin
            got = 1'b1;
            cyc = c;
            return;
         end
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({ihit, dhit, ierr, derr} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000", {ihit, dhit, ierr, derr});
      end
      n_cmp++;
      if ({iload, dload} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_loads: got %h %h want 0 0", iload, dload);
      end
      n_cmp++;
      if ({rif.addr, rif.wen, rif.ren, rif.store} !== 69'd0) begin
         n_fail++;
         $display("FAIL reset_ramif: got addr %h wen %b ren %b store %h want 0", rif.addr, rif.wen, rif.ren, rif.store);
      end
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_ifetch();
      bit   got;
      int   cyc;
      exp_t e;
      ram_mode = 0; ram_busy = 2; use_addr_data = 1'b0; ram_data = 32'hDEAD_BEEF;
      iaddr = 32'h0000_0100; iren = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 32'hDEAD_BEEF));
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_cmp++;
         if ({rif.ren, rif.wen, rif.addr} !== {1'b1, 4'd0, 32'h100}) begin
            n_fail++;
            $display("FAIL ifetch_ramif c%0d: got ren %b wen %b addr %h want 1 0000 100", c, rif.ren, rif.wen, rif.addr);
         end
      end
      wait_hit(4, got, cyc);
      n_cmp++;
      if (!got || cyc != 1) begin
         n_fail++;
         $display("FAIL ifetch_latency: got hit %0d after %0d more cycles want hit after 1", got, cyc);
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs(e.port_d) !== {1'b1, 1'b0, e.err, e.load}) begin
            n_fail++;
            $display("FAIL ifetch_resp: got %h want %h", obs(e.port_d), {1'b1, 1'b0, e.err, e.load});
         end
      end
      iren = 1'b0;
      tick();
      n_cmp++;
      if ({ihit, dhit, rif.ren} !== 3'b000) begin
         n_fail++;
         $display("FAIL ifetch_pulse: got ihit %b dhit %b ren %b want 000", ihit, dhit, rif.ren);
      end
   endtask

   task automatic test_write();
      bit   got;
      int   cyc;
      exp_t e;
      ram_mode = 0; ram_busy = 1; use_addr_data = 1'b0; ram_data = 32'hCAFE_0001;
      daddr = 32'h200; dwen = 4'b0011; dstore = 32'h1234_5678; dren = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, 32'hCAFE_0001));
      tick();
      n_cmp++;
      if ({rif.wen, rif.ren, rif.store, rif.addr} !== {4'b0011, 1'b0, 32'h1234_5678, 32'h200}) begin
         n_fail++;
         $display("FAIL write_ramif: got wen %b ren %b store %h addr %h want 0011 0 12345678 200", rif.wen, rif.ren, rif.store, rif.addr);
      end
      wait_hit(6, got, cyc);
      n_cmp++;
      if (!got || cyc != 2) begin
         n_fail++;
         $display("FAIL write_latency: got hit %0d after %0d more cycles want hit after 2", got, cyc);
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs(e.port_d) !== {1'b1, 1'b0, e.err, e.load}) begin
            n_fail++;
            $display("FAIL write_resp: got %h want %h", obs(e.port_d), {1'b1, 1'b0, e.err, e.load});
         end
      end
      dren = 1'b0; dwen = 4'd0;
      tick();
   endtask

   task automatic test_round_robin();
      int   hits;
      int   want_cyc;
      exp_t e;
      ram_mode = 0; ram_busy = 0; use_addr_data = 1'b1;
      iaddr = 32'h300; daddr = 32'h400; dwen = 4'd0;
      nrst = 1'b0;
      iren = 1'b1; dren = 1'b1;
      #2;
      nrst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(mk(1'b1, 1'b0, 32'h5A5A_0400));
         exp_q.push_back(mk(1'b0, 1'b0, 32'h5A5A_0300));
      end
      hits = 0;
      for (int c = 1; c <= 14 && hits < 4; c++) begin
         tick();
         n_cmp++;
         if (ihit && dhit) begin
            n_fail++;
            $display("FAIL rr_exclusive c%0d: got ihit 1 dhit 1 want at most one", c);
         end
         if (ihit || dhit) begin
            want_cyc = 2 + 3 * hits;
            e = exp_q.pop_front();
            n_cmp++;
            if (c != want_cyc) begin
               n_fail++;
               $display("FAIL rr_cycle hit%0d: got cycle %0d want %0d", hits, c, want_cyc);
            end
            n_cmp++;
            if (obs(e.port_d) !== {1'b1, 1'b0, e.err, e.load}) begin
               n_fail++;
               $display("FAIL rr_order hit%0d: got %h want %h", hits, obs(e.port_d), {1'b1, 1'b0, e.err, e.load});
            end
            hits++;
         end
      end
      n_cmp++;
      if (hits != 4) begin
         n_fail++;
         $display("FAIL rr_count: got %0d hits want 4", hits);
         while (exp_q.size() > hits) void'(exp_q.pop_back());
      end
      iren = 1'b0; dren = 1'b0;
      tick();
   endtask

   task automatic test_ram_error();
      bit   got;
      int   cyc;
      exp_t e;
      ram_mode = 1; ram_busy = 1; use_addr_data = 1'b0; ram_data = 32'hBAD0_BAD0;
      iaddr = 32'h500; iren = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b1, 32'h0));
      wait_hit(8, got, cyc);
      n_cmp++;
      if (!got || cyc != 3) begin
         n_fail++;
         $display("FAIL error_latency: got hit %0d after %0d cycles want hit after 3", got, cyc);
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs(e.port_d) !== {1'b1, 1'b0, e.err, e.load}) begin
            n_fail++;
            $display("FAIL error_resp: got %h want %h", obs(e.port_d), {1'b1, 1'b0, e.err, e.load});
         end
      end
      n_cmp++;
      if (dload !== 32'h5A5A_0400) begin
         n_fail++;
         $display("FAIL error_dload_hold: got %h want 5a5a0400", dload);
      end
      iren = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      bit   got;
      int   cyc;
      int   ren_cnt;
      exp_t e;
      // DONE lands on the same cycle the watchdog expires; DONE must win.
      ram_mode = 0; ram_busy = TO - 1; use_addr_data = 1'b0; ram_data = 32'h0BEE_0001;
      daddr = 32'h600; dren = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, 32'h0BEE_0001));
      wait_hit(10, got, cyc);
      n_cmp++;
      if (!got || cyc != TO + 1) begin
         n_fail++;
         $display("FAIL race_latency: got hit %0d after %0d cycles want hit after %0d", got, cyc, TO + 1);
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs(e.port_d) !== {1'b1, 1'b0, e.err, e.load}) begin
            n_fail++;
            $display("FAIL race_resp: got %h want %h", obs(e.port_d), {1'b1, 1'b0, e.err, e.load});
         end
      end
      dren = 1'b0;
      tick();
      ram_mode = 2; daddr = 32'h700; dren = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b1, 32'h0));
      got = 1'b0; cyc = 0; ren_cnt = 0;
      for (int c = 1; c <= 12 && !got; c++) begin
         tick();
         if (rif.ren) ren_cnt++;
         if (ihit || dhit) begin
            got = 1'b1;
            cyc = c;
         end
      end
      n_cmp++;
      if (!got || cyc != TO + 1 || ren_cnt != TO) begin
         n_fail++;
         $display("FAIL timeout_len: got hit %0d at cycle %0d after %0d access cycles want hit at %0d after %0d", got, cyc, ren_cnt, TO + 1, TO);
      end
      if (got) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs(e.port_d) !== {1'b1, 1'b0, e.err, e.load}) begin
            n_fail++;
            $display("FAIL timeout_resp: got %h want %h", obs(e.port_d), {1'b1, 1'b0, e.err, e.load});
         end
      end
      dren = 1'b0;
      ram_mode = 0; ram_busy = 0; ram_data = 32'h1111_2222;
      iaddr = 32'h800; iren = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 32'h1111_2222));
      tick();
      tick();
      n_cmp++;
      if ({rif.ren, rif.addr} !== {1'b1, 32'h800}) begin
         n_fail++;
         $display("FAIL timeout_next: got ren %b addr %h want 1 800", rif.ren, rif.addr);
      end
      wait_hit(4, got, cyc);
      n_cmp++;
      if (!got || cyc != 1) begin
         n_fail++;
         $display("FAIL timeout_next_hit: got hit %0d after %0d cycles want hit after 1", got, cyc);
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs(e.port_d) !== {1'b1, 1'b0, e.err, e.load}) begin
            n_fail++;
            $display("FAIL timeout_next_resp: got %h want %h", obs(e.port_d), {1'b1, 1'b0, e.err, e.load});
         end
      end
      iren = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access();
      bit   got;
      int   cyc;
      exp_t e;
      ram_mode = 2; use_addr_data = 1'b0; ram_data = 32'h7777_8888;
      iaddr = 32'h900; iren = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (rif.ren !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre: got ren %b want 1", rif.ren);
      end
      nrst = 1'b0;
      #1;
      n_cmp++;
      if ({ihit, dhit, ierr, derr, iload, dload} !== 68'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got hit %b%b err %b%b iload %h dload %h want all 0", ihit, dhit, ierr, derr, iload, dload);
      end
      n_cmp++;
      if ({rif.addr, rif.wen, rif.ren, rif.store} !== 69'd0) begin
         n_fail++;
         $display("FAIL midrst_ramif: got addr %h wen %b ren %b store %h want 0", rif.addr, rif.wen, rif.ren, rif.store);
      end
      tick();
      ram_mode = 0; ram_busy = 0;
      nrst = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 32'h7777_8888));
      wait_hit(6, got, cyc);
      n_cmp++;
      if (!got || cyc != 2) begin
         n_fail++;
         $display("FAIL midrst_regrant: got hit %0d after %0d cycles want hit after 2", got, cyc);
      end else begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs(e.port_d) !== {1'b1, 1'b0, e.err, e.load}) begin
            n_fail++;
            $display("FAIL midrst_resp: got %h want %h", obs(e.port_d), {1'b1, 1'b0, e.err, e.load});
         end
      end
      iren = 1'b0;
      tick();
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      nrst = 1'b0;
      iren = 1'b0; iaddr = '0; dren = 1'b0; dwen = 4'd0; daddr = '0; dstore = '0;
      ram_busy = 0; ram_mode = 0; ram_data = '0; use_addr_data = 1'b0;
      test_reset();
      test_ifetch();
      test_write();
      test_round_robin();
      test_ram_error();
      test_timeout();
      test_reset_mid_access();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d unmatched expectations want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that merges the core's instruction-fetch and data-access requests onto the single `ram_if` port, driving its `ramctrl` side. One access is in flight at a time; the arbiter holds the RAM request stable until the RAM reports completion. It then returns the load word plus a one-cycle hit (or error) pulse to the winning requester. A watchdog aborts accesses the RAM never completes.

## Interface
- `TIMEOUT`, default 256: maximum ACCESS cycles before the access is aborted; legal range ≥ 1.
- `clk`  in  1  system clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `iren`  in  1  instruction read request; held until `ihit`.
- `iaddr`  in  32 (`word_t`)  instruction address.
- `iload`  out  32  fetched word; valid while `ihit` is 1.
- `ihit`  out  1  one-cycle completion pulse.
- `ierr`  out  1  qualifies `ihit`: access errored or timed out.
- `dren`  in  1  data read request; held until `dhit`.
- `dwen`  in  4  data byte write enables; nonzero means a write request.
- `daddr`  in  32  data address.
- `dstore`  in  32  write data.
- `dload`  out  32  read data; valid while `dhit` is 1.
- `dhit`  out  1  one-cycle completion pulse.
- `derr`  out  1  qualifies `dhit`.
- `ramif`  `ram_if.ramctrl`  drives `addr`, `wen`, `ren`, `store`; samples `load`, `state`.
- `ram_state_t` values used by this block:
  - `RAM_FREE`: idle.
  - `RAM_BUSY`: in progress.
  - `RAM_DONE`: `load` valid or store committed.
  - `RAM_ERROR`: access failed.

## Operation
- FSM states are IDLE, ACCESS and RESP. Registers:
  - `grant_d`: 1 means data granted, 0 means instruction.
  - `last_d`: last grant was data.
  - latched request fields.
  - watchdog counter, width `$clog2(TIMEOUT+1)`.
  - registered `iload`/`dload`/hit/err.
- IDLE, arbitration:
  - Data pending (`dren | (dwen != 0)`) and no instruction pending: grant data.
  - Only instruction pending: grant instruction.
  - Both pending: grant data if `last_d == 0`, else grant instruction. This alternates grants and prevents starvation.
  - On a grant: latch addr, wen, ren and store; set `last_d = grant_d`; clear the counter; go to ACCESS.
- Write/read resolution:
  - Data grant with `dwen != 0`: a write (`wen = dwen`, `ren = 0`). `dren` is ignored when both are set.
  - Data read: `wen = 0`, `ren = 1`.
  - Instruction grant: always a read.
- ACCESS:
  - `ramif.addr/wen/ren/store` are driven from the latched fields and held constant.
  - The counter increments each cycle.
  - On `state == RAM_DONE`: capture `ramif.load` into the granted port's load register (writes capture it too), err = 0, go to RESP.
  - On `state == RAM_ERROR`: load = 0, err = 1, go to RESP.
  - On counter reaching `TIMEOUT - 1` without DONE or ERROR: load = 0, err = 1, go to RESP.
  - DONE and ERROR are both checked before the timeout, so they win in the same cycle.
- RESP:
  - The granted port's hit = 1 and its err as captured; the other port's hit/err = 0.
  - `ramif.wen/ren/addr/store` = 0.
  - Always returns to IDLE next cycle.
  - The RESP cycle guarantees that a request still presented during the hit cycle is never re-issued.
- If a requester withdraws its request during ACCESS, the access still completes and the hit is still pulsed.
- Outside ACCESS, all `ramif` outputs are 0.
- The load registers hold their value until the next completion for that port.

## Timing
- Reset (`nrst` low, asynchronous, at any time including mid-ACCESS):
  - FSM = IDLE; `last_d` = 0; counter = 0.
  - `iload`, `dload`, `ihit`, `dhit`, `ierr`, `derr` = 0.
  - `ramif.addr/wen/ren/store` = 0.
  - The in-flight RAM access is abandoned; no hit is produced.
- Latency, with the request seen in IDLE at cycle 0:
  - `ramif` driven in cycles 1..k.
  - `state == RAM_DONE` sampled in cycle k.
  - hit in cycle k+1.
  - IDLE in cycle k+2, where the next request is sampled.
  - Minimum is hit at cycle 2 with back-to-back grants every 3 cycles.
- Timeout: with no DONE, hit+err appears in cycle `TIMEOUT + 1`.
- `ihit` and `dhit` are never high in the same cycle; each is high for exactly one cycle per access.

## Test plan
- Instruction read of `0x0000_0100`; RAM BUSY for 2 cycles, then DONE with load `0xDEADBEEF` -> `ramif.ren=1`, addr `0x100` held for 3 cycles; `ihit=1`, `iload=0xDEADBEEF`, `ierr=0` for one cycle; `dhit` stays 0.
- Data write `daddr=0x200`, `dwen=4'b0011`, `dstore=0x1234_5678`, with `dren=1` also set -> `ramif.wen=4'b0011`, `ren=0`, `store=0x12345678` until DONE; then `dhit=1`.
- Both ports request continuously after reset, with RAM DONE immediately -> grant order D, I, D, I; each hit 3 cycles apart; no starvation.
- `TIMEOUT=4`, RAM stuck at BUSY -> 4 ACCESS cycles, then `derr=1` with `dhit=1` and `dload=0`; the next request is accepted 2 cycles later.
- RAM returns `RAM_ERROR` on an instruction read -> `ihit=1`, `ierr=1`, `iload=0`.
- `nrst` pulsed low in the middle of ACCESS -> all outputs immediately 0, no hit; after release, a pending instruction request is granted from IDLE.
